// File: rtl/mux_pkg.sv
// Shared definitions for the mux_nto1_scan channel selector: mode encodings
// and the select/dwell width helper.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to index `count` items, never less than one.
  function automatic int width_of(input int count);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < count) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan sequencer for mux_nto1_scan: dwell counter plus channel counter that
// walks channels 0..N-1, spending DWELL enabled cycles on each.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 1,
  localparam int SW   = width_of(N),
  localparam int DW   = width_of(DWELL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [SW-1:0] scan_ch,
  output logic          adv_wrap
);

  logic [SW-1:0] scan_ch_q, scan_ch_d;
  logic [DW-1:0] dwell_q,   dwell_d;
  logic          wrap_pend_q, wrap_pend_d;

  // wrap_pend marks that scan_ch has just come round from N-1 to 0 and that
  // channel 0 has not been emitted yet; the top uses it to time the wrap pulse.
  always_comb begin
    scan_ch_d   = scan_ch_q;
    dwell_d     = dwell_q;
    wrap_pend_d = wrap_pend_q;
    if (en) begin
      if (clr) begin
        scan_ch_d   = '0;
        dwell_d     = '0;
        wrap_pend_d = 1'b0;
      end else if (dwell_q == DW'(DWELL - 1)) begin
        dwell_d     = '0;
        wrap_pend_d = (scan_ch_q == SW'(N - 1));
        scan_ch_d   = (scan_ch_q == SW'(N - 1)) ? '0 : scan_ch_q + SW'(1);
      end else begin
        dwell_d     = dwell_q + DW'(1);
        wrap_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ch_q   <= '0;
      dwell_q     <= '0;
      wrap_pend_q <= 1'b0;
    end else begin
      scan_ch_q   <= scan_ch_d;
      dwell_q     <= dwell_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end

  assign scan_ch  = scan_ch_q;
  assign adv_wrap = wrap_pend_q;

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 mux of W-bit channels with direct and scan modes.
// Optional MUX_PARITY_EN adds dout_par, the XOR of the data loaded into dout.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SW   = width_of(N),
  localparam int DW   = width_of(DWELL)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  ch_out,
  output logic           valid,
`ifdef MUX_PARITY_EN
  output logic           dout_par,
`endif
  output logic           wrap
);

  logic [SW-1:0] scan_ch;
  logic          adv_wrap;
  logic          clr;

  assign clr = (mode == MODE_DIRECT);

  mux_scan_ctr #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .scan_ch  (scan_ch),
    .adv_wrap (adv_wrap)
  );

  logic [SW-1:0] sel_eff;
  logic [SW-1:0] src_ch;
  logic [W-1:0]  ch_data;

  logic [W-1:0]  dout_q,  dout_d;
  logic [SW-1:0] ch_q,    ch_d;
  logic          valid_q, valid_d;
  logic          wrap_q,  wrap_d;
  logic          par_q,   par_d;

  // Selects beyond the last channel fall back to channel N-1.
  always_comb begin
    sel_eff = (sel > SW'(N - 1)) ? SW'(N - 1) : sel;
    src_ch  = (mode == MODE_SCAN) ? scan_ch : sel_eff;
    ch_data = din[int'(src_ch) * W +: W];
  end

  always_comb begin
    dout_d  = dout_q;
    ch_d    = ch_q;
    par_d   = par_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      dout_d  = ch_data;
      ch_d    = src_ch;
      par_d   = ^ch_data;
      valid_d = 1'b1;
      wrap_d  = (mode == MODE_SCAN) && adv_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      par_q   <= par_d;
    end
  end

  assign dout   = dout_q;
  assign ch_out = ch_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;
`ifdef MUX_PARITY_EN
  assign dout_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: three instances (N4/W8/DWELL3, N3/W4/DWELL1,
// N4/W8/DWELL2) checked against constants and a cycle-count reference model.
module tb_mux_nto1_scan;

  localparam int NP [3] = '{4, 3, 4};
  localparam int WP [3] = '{8, 4, 8};
  localparam int DP [3] = '{3, 1, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] din_i  [3];
  logic [1:0]  sel_i  [3];
  logic        mode_i [3];
  logic        en_i   [3];

  logic [7:0] dout_a, dout_c;
  logic [3:0] dout_b;
  logic [1:0] ch_a, ch_b, ch_c;
  logic       valid_a, valid_b, valid_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       par_a, par_b, par_c;

  logic [7:0] dout_o  [3];
  logic [1:0] ch_o    [3];
  logic       valid_o [3];
  logic       wrap_o  [3];
  logic       par_o   [3];

  assign dout_o[0] = dout_a;  assign dout_o[1] = {4'b0, dout_b};  assign dout_o[2] = dout_c;
  assign ch_o[0]   = ch_a;    assign ch_o[1]   = ch_b;            assign ch_o[2]   = ch_c;
  assign valid_o[0] = valid_a; assign valid_o[1] = valid_b; assign valid_o[2] = valid_c;
  assign wrap_o[0]  = wrap_a;  assign wrap_o[1]  = wrap_b;  assign wrap_o[2]  = wrap_c;
  assign par_o[0]   = par_a;   assign par_o[1]   = par_b;   assign par_o[2]   = par_c;

`ifndef MUX_PARITY_EN
  assign par_a = 1'b0;
  assign par_b = 1'b0;
  assign par_c = 1'b0;
`endif

  mux_nto1_scan #(.N(4), .W(8), .DWELL(3)) u_a (
    .clk (clk), .rst_n (rst_n), .din (din_i[0]), .sel (sel_i[0]),
    .mode (mode_i[0]), .en (en_i[0]), .dout (dout_a), .ch_out (ch_a),
    .valid (valid_a),
`ifdef MUX_PARITY_EN
    .dout_par (par_a),
`endif
    .wrap (wrap_a)
  );

  mux_nto1_scan #(.N(3), .W(4), .DWELL(1)) u_b (
    .clk (clk), .rst_n (rst_n), .din (din_i[1][11:0]), .sel (sel_i[1]),
    .mode (mode_i[1]), .en (en_i[1]), .dout (dout_b), .ch_out (ch_b),
    .valid (valid_b),
`ifdef MUX_PARITY_EN
    .dout_par (par_b),
`endif
    .wrap (wrap_b)
  );

  mux_nto1_scan #(.N(4), .W(8), .DWELL(2)) u_c (
    .clk (clk), .rst_n (rst_n), .din (din_i[2]), .sel (sel_i[2]),
    .mode (mode_i[2]), .en (en_i[2]), .dout (dout_c), .ch_out (ch_c),
    .valid (valid_c),
`ifdef MUX_PARITY_EN
    .dout_par (par_c),
`endif
    .wrap (wrap_c)
  );

  // ---------------- reference model ----------------
  // k counts enabled scan cycles since the last clear; the emitted channel is
  // (k / DWELL) mod N and wrap fires whenever k reaches a whole lap again.
  typedef struct {
    int         k;
    logic [7:0] dout;
    int         ch;
    logic       valid;
    logic       wrap;
    logic       par;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t reset_state();
    mstate_t r;
    r.k = 0; r.dout = '0; r.ch = 0; r.valid = 1'b0; r.wrap = 1'b0; r.par = 1'b0;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input int i);
    mstate_t r;
    int c, n, w, d;
    r = s; n = NP[i]; w = WP[i]; d = DP[i];
    r.valid = en_i[i];
    r.wrap  = 1'b0;
    if (en_i[i]) begin
      if (mode_i[i] == 1'b0) begin
        c   = (int'(sel_i[i]) >= n) ? n - 1 : int'(sel_i[i]);
        r.k = 0;
      end else begin
        c      = (s.k / d) % n;
        r.wrap = (s.k > 0) && (s.k % (n * d) == 0);
        r.k    = s.k + 1;
      end
      r.ch   = c;
      r.dout = 8'((din_i[i] >> (c * w)) & ((32'd1 << w) - 32'd1));
      r.par  = ^r.dout;
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int i, input string tag);
    check($sformatf("%s.u%0d.dout", tag, i), 32'(dout_o[i]), 32'(m[i].dout));
    check($sformatf("%s.u%0d.ch", tag, i), 32'(ch_o[i]), m[i].ch);
    check($sformatf("%s.u%0d.valid", tag, i), 32'(valid_o[i]), 32'(m[i].valid));
    check($sformatf("%s.u%0d.wrap", tag, i), 32'(wrap_o[i]), 32'(m[i].wrap));
`ifdef MUX_PARITY_EN
    check($sformatf("%s.u%0d.par", tag, i), 32'(par_o[i]), 32'(m[i].par));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m[i] = rst_n ? model_step(m[i], i) : reset_state();
    end
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) en_i[i] = 1'b0;
  endtask

  task automatic drive(input int i, input logic mode, input logic en,
                       input logic [1:0] sel, input logic [31:0] din);
    mode_i[i] = mode; en_i[i] = en; sel_i[i] = sel; din_i[i] = din;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        en;
    logic [31:0] din;
    logic [7:0]  e_dout;
    logic [1:0]  e_ch;
    logic        e_valid;
  } vec_t;

  vec_t tbl [6];
  logic [1:0] seq_gate [8];
  logic       val_gate [8];
  logic [1:0] seq_sw   [9];

  initial begin
    // ---- reset held with toggling inputs ----
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), $urandom);
      m[i] = reset_state();
    end
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) din_i[i] = $urandom;
      tick();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rst.u%0d.dout", i), 32'(dout_o[i]), 32'h0);
        check($sformatf("rst.u%0d.ch", i), 32'(ch_o[i]), 32'h0);
        check($sformatf("rst.u%0d.valid", i), 32'(valid_o[i]), 32'h0);
        check($sformatf("rst.u%0d.wrap", i), 32'(wrap_o[i]), 32'h0);
      end
    end
    idle_all();
    for (int i = 0; i < 3; i++) mode_i[i] = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) check_dut(i, "post_rst");

    // ---- direct mode table on N=4, W=8 ----
    tbl[0] = '{2'd0, 1'b1, 32'hDDCCBBAA, 8'hAA, 2'd0, 1'b1};
    tbl[1] = '{2'd1, 1'b1, 32'hDDCCBBAA, 8'hBB, 2'd1, 1'b1};
    tbl[2] = '{2'd2, 1'b1, 32'hDDCCBBAA, 8'hCC, 2'd2, 1'b1};
    tbl[3] = '{2'd3, 1'b1, 32'hDDCCBBAA, 8'hDD, 2'd3, 1'b1};
    tbl[4] = '{2'd0, 1'b0, 32'h11223344, 8'hDD, 2'd3, 1'b0};
    tbl[5] = '{2'd0, 1'b1, 32'h11223344, 8'h44, 2'd0, 1'b1};
    for (int v = 0; v < 6; v++) begin
      drive(0, 1'b0, tbl[v].en, tbl[v].sel, tbl[v].din);
      tick();
      check($sformatf("direct[%0d].dout", v), 32'(dout_a), 32'(tbl[v].e_dout));
      check($sformatf("direct[%0d].ch", v), 32'(ch_a), 32'(tbl[v].e_ch));
      check($sformatf("direct[%0d].valid", v), 32'(valid_a), 32'(tbl[v].e_valid));
      check($sformatf("direct[%0d].wrap", v), 32'(wrap_a), 32'h0);
      check_dut(0, "direct_model");
    end
    idle_all();

    // ---- out-of-range select on N=3, W=4 ----
    drive(1, 1'b0, 1'b1, 2'd3, 32'h0000_0321);
    tick();
    check("oor.dout", 32'(dout_b), 32'h3);
    check("oor.ch", 32'(ch_b), 32'h2);
    drive(1, 1'b0, 1'b1, 2'd1, 32'h0000_0321);
    tick();
    check("inrange.dout", 32'(dout_b), 32'h2);
    check("inrange.ch", 32'(ch_b), 32'h1);
    idle_all();

    // ---- scan sequence on N=4, DWELL=3 ----
    drive(0, 1'b0, 1'b1, 2'd0, 32'hDDCCBBAA);
    tick();
    for (int c = 0; c < 4; c++) for (int r = 0; r < 3; r++) exp_q.push_back(2'(c));
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    drive(0, 1'b1, 1'b1, 2'd3, 32'hDDCCBBAA);
    for (int j = 0; j < 14; j++) begin
      logic [1:0]  e_ch;
      logic [31:0] bytes;
      tick();
      e_ch  = exp_q.pop_front();
      bytes = 32'hDDCCBBAA;
      check($sformatf("scan[%0d].ch", j), 32'(ch_a), 32'(e_ch));
      check($sformatf("scan[%0d].dout", j), 32'(dout_a), 32'(bytes[e_ch*8 +: 8]));
      check($sformatf("scan[%0d].wrap", j), 32'(wrap_a), 32'(j == 12));
      check($sformatf("scan[%0d].valid", j), 32'(valid_a), 32'h1);
    end

    // ---- reset asserted between edges, mid-dwell ----
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) m[i] = reset_state();
    check("async_rst.dout", 32'(dout_a), 32'h0);
    check("async_rst.ch", 32'(ch_a), 32'h0);
    check("async_rst.valid", 32'(valid_a), 32'h0);
    for (int c = 0; c < 2; c++) begin
      din_i[0] = $urandom;
      tick();
      check("rst_hold.dout", 32'(dout_a), 32'h0);
      check("rst_hold.valid", 32'(valid_a), 32'h0);
    end
    din_i[0] = 32'hDDCCBBAA;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("rst_restart[%0d].ch", j), 32'(ch_a), (j < 3) ? 32'h0 : 32'h1);
      check_dut(0, "rst_restart");
    end
    idle_all();

    // ---- enable gating on N=4, DWELL=2 ----
    seq_gate = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    val_gate = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(2, 1'b0, 1'b1, 2'd0, 32'h44332211);
    tick();
    mode_i[2] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      en_i[2] = (j < 3);
      tick();
      check($sformatf("gate[%0d].ch", j), 32'(ch_c), 32'(seq_gate[j]));
      check($sformatf("gate[%0d].valid", j), 32'(valid_c), 32'(val_gate[j]));
      check($sformatf("gate[%0d].wrap", j), 32'(wrap_c), 32'h0);
    end
    en_i[2] = 1'b1;
    tick();
    check("gate_resume.ch", 32'(ch_c), 32'h1);
    check("gate_resume.valid", 32'(valid_c), 32'h1);
    tick();
    check("gate_next.ch", 32'(ch_c), 32'h2);
    check("gate_next.dout", 32'(dout_c), 32'h33);

    // ---- mode switch scan -> direct -> scan ----
    seq_sw = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1};
    drive(2, 1'b0, 1'b1, 2'd0, 32'h44332211);
    tick();
    for (int j = 0; j < 9; j++) begin
      mode_i[2] = (j != 5);
      sel_i[2]  = 2'd1;
      tick();
      check($sformatf("modesw[%0d].ch", j), 32'(ch_c), 32'(seq_sw[j]));
      check_dut(2, "modesw");
    end
    idle_all();

`ifdef MUX_PARITY_EN
    drive(0, 1'b0, 1'b1, 2'd0, 32'h000000A7);
    tick();
    check("par_a7", 32'(par_a), 32'h1);
    drive(0, 1'b0, 1'b1, 2'd0, 32'h000000A6);
    tick();
    check("par_a6", 32'(par_a), 32'h0);
    en_i[0] = 1'b0;
    din_i[0] = 32'h000000A7;
    tick();
    check("par_hold", 32'(par_a), 32'h0);
`endif

    // ---- randomized against the reference model ----
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        en_i[i]  = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 9) == 0) mode_i[i] = ~mode_i[i];
        sel_i[i] = 2'($urandom_range(0, 3));
        din_i[i] = $urandom;
      end
      tick();
      for (int i = 0; i < 3; i++) check_dut(i, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
